// File: rtl/e_mdu_pkg.sv
// Shared op codes, default latencies and the HI/LO payload type for the execute-stage MDU.
package e_mdu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] MDU_NONE  = 3'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 3'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 3'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 3'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] MDU_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] MDU_MTLO  = 3'd6;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational 64-bit product and quotient/remainder for the latched MDU operation.
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output hilo_t           res,
  output logic            wr
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den_s;
  logic [31:0] den_u;
  logic [31:0] uq, ur;
  logic [31:0] sq_mag, sr_mag;
  logic [31:0] sq, sr;
  logic        ovf;

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes so no simulator-defined overflow is involved;
  // a zero divisor is swapped for 1 to keep the datapath X-free (result is discarded).
  assign b_zero = (b == 32'd0);
  assign mag_a  = a[31] ? (~a + 32'd1) : a;
  assign mag_b  = b[31] ? (~b + 32'd1) : b;
  assign den_s  = b_zero ? 32'd1 : mag_b;
  assign den_u  = b_zero ? 32'd1 : b;
  assign uq     = a / den_u;
  assign ur     = a % den_u;
  assign sq_mag = mag_a / den_s;
  assign sr_mag = mag_a % den_s;
  assign sq     = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr     = a[31] ? (~sr_mag + 32'd1) : sr_mag;
  assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Select the HI/LO result and whether it may be committed.
  always_comb begin
    res = '0;
    wr  = 1'b0;
    case (op)
      MDU_MULT: begin
        res.hi = prod_s[63:32];
        res.lo = prod_s[31:0];
        wr     = 1'b1;
      end
      MDU_MULTU: begin
        res.hi = prod_u[63:32];
        res.lo = prod_u[31:0];
        wr     = 1'b1;
      end
      MDU_DIV: begin
        if (ovf) begin
          res.hi = 32'd0;
          res.lo = 32'h8000_0000;
        end else begin
          res.hi = sr;
          res.lo = sq;
        end
        wr = !b_zero;
      end
      MDU_DIVU: begin
        res.hi = ur;
        res.lo = uq;
        wr     = !b_zero;
      end
      default: begin
        res = '0;
        wr  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div, mthi/mtlo, HI/LO storage.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            E_Start,
  input  logic [OP_W-1:0] E_MDUOp,
  input  logic [31:0]     E_RS,
  input  logic [31:0]     E_RT,
  output logic            E_Busy,
  output logic [31:0]     E_HI,
  output logic [31:0]     E_LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  op_q;
  logic [31:0]      rs_q;
  logic [31:0]      rt_q;
  hilo_t            hilo_q;
  hilo_t            ar_res;
  logic             ar_wr;

  // Arithmetic always works from the latched operands, never the live forwarded values.
  e_mdu_arith u_arith (
    .op  (op_q),
    .a   (rs_q),
    .b   (rt_q),
    .res (ar_res),
    .wr  (ar_wr)
  );

  // Accept/countdown/commit control plus the architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      op_q   <= MDU_NONE;
      rs_q   <= '0;
      rt_q   <= '0;
      hilo_q <= '0;
    end else if (busy) begin
      // Requests arriving while busy (including on the completion edge) are dropped.
      if (cnt == CNT_W'(1)) begin
        if (ar_wr) hilo_q <= ar_res;
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (E_Start) begin
      case (E_MDUOp)
        MDU_MULT, MDU_MULTU: begin
          op_q <= E_MDUOp;
          rs_q <= E_RS;
          rt_q <= E_RT;
          cnt  <= CNT_W'(MULT_CYCLES);
          busy <= 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          op_q <= E_MDUOp;
          rs_q <= E_RS;
          rt_q <= E_RT;
          cnt  <= CNT_W'(DIV_CYCLES);
          busy <= 1'b1;
        end
        MDU_MTHI: hilo_q.hi <= E_RS;
        MDU_MTLO: hilo_q.lo <= E_RS;
        default: ;
      endcase
    end
  end

  assign E_Busy = busy;
  assign E_HI   = hilo_q.hi;
  assign E_LO   = hilo_q.lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: vector table with scoreboard plus multi-cycle corner sequences.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int unsigned NMULT = 5;
  localparam int unsigned NDIV  = 10;
  localparam int unsigned NVEC  = 15;

  logic        clk;
  logic        reset;
  logic        E_Start;
  logic [2:0]  E_MDUOp;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int n_checks = 0;
  int n_err    = 0;

  hilo_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int unsigned cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[NVEC];

  e_mdu dut (
    .clk     (clk),
    .reset   (reset),
    .E_Start (E_Start),
    .E_MDUOp (E_MDUOp),
    .E_RS    (E_RS),
    .E_RT    (E_RT),
    .E_Busy  (E_Busy),
    .E_HI    (E_HI),
    .E_LO    (E_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    hilo_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: scoreboard empty got %h expected entry", name, E_HI);
    end else begin
      e = sb.pop_front();
      chk({name, ".hi"}, E_HI, e.hi);
      chk({name, ".lo"}, E_LO, e.lo);
    end
  endtask

  // Counts busy cycles from the current negedge; leaves the bench in the first non-busy cycle.
  task automatic count_busy(output int n);
    n = 0;
    while (E_Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int unsigned cyc,
                        input logic [31:0] hi, input logic [31:0] lo);
    int n;
    @(negedge clk);
    E_Start = 1'b1; E_MDUOp = op; E_RS = rs; E_RT = rt;
    sb.push_back('{hi: hi, lo: lo});
    @(negedge clk);
    E_Start = 1'b0; E_MDUOp = MDU_NONE; E_RS = $urandom; E_RT = $urandom;
    count_busy(n);
    chk({name, ".busy_cycles"}, 32'(n), 32'(cyc));
    pop_check(name);
  endtask

  initial begin
    int n;
    reset = 1'b0; E_Start = 1'b0; E_MDUOp = MDU_NONE; E_RS = '0; E_RT = '0;

    vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'h0000_0002, NMULT, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, NMULT, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, NDIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MDU_DIVU,  32'h0000_0007, 32'h0000_0000, NDIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, NDIV,  32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{MDU_DIVU,  32'h0000_0064, 32'h0000_0007, NDIV,  32'h0000_0002, 32'h0000_000E};
    vecs[6]  = '{MDU_MULT,  32'h0001_0000, 32'h0001_0000, NMULT, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, NDIV,  32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{MDU_MTHI,  32'hDEAD_BEEF, 32'h0000_0000, 0,     32'hDEAD_BEEF, 32'hFFFF_FFFD};
    vecs[9]  = '{MDU_MTLO,  32'h0BAD_F00D, 32'h0000_0000, 0,     32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[10] = '{MDU_NONE,  32'h1111_1111, 32'h0000_0001, 0,     32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[11] = '{3'd7,      32'h2222_2222, 32'h0000_0001, 0,     32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[12] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NMULT, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[13] = '{MDU_DIV,   32'h0000_0000, 32'h0000_0005, NDIV,  32'h0000_0000, 32'h0000_0000};
    vecs[14] = '{MDU_DIV,   32'h8000_0000, 32'h0000_0003, NDIV,  32'hFFFF_FFFE, 32'hD555_5556};

    // Reset state, held and just after release.
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(E_Busy), 32'd0);
    chk("rst.hi", E_HI, 32'd0);
    chk("rst.lo", E_LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel.busy", 32'(E_Busy), 32'd0);

    // Table-driven ops.
    for (int i = 0; i < int'(NVEC); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].cyc, vecs[i].hi, vecs[i].lo);
    end

    // Start requests during busy are ignored; result uses latched operands.
    @(negedge clk);
    E_Start = 1'b1; E_MDUOp = MDU_MULT; E_RS = 32'd3; E_RT = 32'd4;
    sb.push_back('{hi: 32'd0, lo: 32'd12});
    @(negedge clk);
    E_Start = 1'b0; E_MDUOp = MDU_NONE;
    n = 0;
    while (E_Busy === 1'b1 && n < 200) begin
      n++;
      if (n == 2) begin E_Start = 1'b1; E_MDUOp = MDU_MTHI; E_RS = 32'h0000_AAAA; E_RT = 32'd9; end
      if (n == 3) begin E_MDUOp = MDU_DIV; E_RS = 32'd100; E_RT = 32'd1; end
      if (n == 4) begin E_Start = 1'b0; E_MDUOp = MDU_NONE; end
      @(negedge clk);
    end
    chk("ign.busy_cycles", 32'(n), 32'(NMULT));
    pop_check("ign");
    run_op("mthi", MDU_MTHI, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'd12);

    // Start held across the completion edge is taken one cycle after busy falls.
    @(negedge clk);
    E_Start = 1'b1; E_MDUOp = MDU_MULT; E_RS = 32'd2; E_RT = 32'd3;
    sb.push_back('{hi: 32'd0, lo: 32'd6});
    @(negedge clk);
    E_MDUOp = MDU_DIVU; E_RS = 32'd20; E_RT = 32'd6;
    sb.push_back('{hi: 32'd2, lo: 32'd3});
    count_busy(n);
    chk("b2b.first_cycles", 32'(n), 32'(NMULT));
    pop_check("b2b.first");
    @(negedge clk);
    E_Start = 1'b0; E_MDUOp = MDU_NONE; E_RS = $urandom; E_RT = $urandom;
    chk("b2b.second_started", 32'(E_Busy), 32'd1);
    count_busy(n);
    chk("b2b.second_cycles", 32'(n), 32'(NDIV));
    pop_check("b2b.second");

    // Asynchronous reset mid-divide aborts it with no later commit.
    @(negedge clk);
    E_Start = 1'b1; E_MDUOp = MDU_DIV; E_RS = 32'd100; E_RT = 32'd7;
    @(negedge clk);
    E_Start = 1'b0; E_MDUOp = MDU_NONE;
    repeat (3) @(negedge clk);
    chk("abort.busy_before", 32'(E_Busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort.busy", 32'(E_Busy), 32'd0);
    chk("abort.hi", E_HI, 32'd0);
    chk("abort.lo", E_LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort.busy_late", 32'(E_Busy), 32'd0);
    chk("abort.hi_late", E_HI, 32'd0);
    chk("abort.lo_late", E_LO, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the five-stage pipeline.
- Performs mult/multu/div/divu with fixed multi-cycle latency and handles mthi/mtlo.
- Holds the architectural HI/LO registers and drives them to the E/M pipeline register, which feeds the memory-stage HI/LO write-data select.
- Reports busy to the hazard unit so that following HI/LO-touching instructions stall in D.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration for div/divu (must be >= 1).

Ports:
- clk  in  1  pipeline clock, rising-edge.
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion.
- E_Start  in  1  one-cycle request; qualifies E_MDUOp. The hazard unit asserts it only for an unstalled, unflushed E instruction.
- E_MDUOp  in  3  operation code: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 is none.
- E_RS  in  32  forwarded rs value (multiplicand/dividend, or mthi/mtlo source).
- E_RT  in  32  forwarded rt value (multiplier/divisor).
- E_Busy  out  1  registered; high while a mult/div is in flight.
- E_HI  out  32  architectural HI.
- E_LO  out  32  architectural LO.

Behaviour:
Reset (reset low, asynchronous):
- E_Busy=0, E_HI=0, E_LO=0, counter=0, latched operands/op=0.
- Reset asserted mid-operation aborts it; no HI/LO update occurs.

Accept:
- At a rising edge with E_Start=1, E_Busy=0 and op in 1..4: latch E_RS, E_RT and op; load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); E_Busy goes 1.

Run:
- Each following edge with E_Busy=1 decrements the counter.
- At the edge where counter==1: write the result into HI/LO, set counter=0, E_Busy=0.
- E_Busy is therefore high for exactly N cycles.
- New HI/LO are visible in cycle k+N+1, where k is the Start cycle. E_Busy is 0 in that same cycle.

mthi/mtlo (ops 5,6):
- Accepted at the edge when E_Start=1 and E_Busy=0.
- HI (or LO) := E_RS. Single cycle, E_Busy stays 0.

Arithmetic:
- mult: {HI,LO} = signed 64-bit product of the latched operands.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient in LO, remainder in HI.
- Results are computed from the latched operands, never from the live E_RS/E_RT.

Boundaries:
- Divisor==0 (div or divu): the busy period runs normally, HI/LO are left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, without relying on simulator-defined overflow.
- E_Start=1 while E_Busy=1: ignored for every op (the hazard unit guarantees it does not occur). The in-flight operation is unaffected.
- E_Start=1 with op 0 or 7: no effect.
- E_Start on the exact completion edge is ignored, because E_Busy is still 1 at that edge. It is accepted the next cycle.

Decomposition:
- Shared constants header: MDU op codes (MDU_NONE..MDU_MTLO), MULT_CYCLES and DIV_CYCLES defaults.
- One natural sub-module, e_mdu_arith: a combinational 64-bit signed/unsigned product and quotient/remainder, including the divide-by-zero and overflow special cases.
- The counter, busy logic and HI/LO registers live in e_mdu.

Test Plan:
- Reset release, then mult with E_RS=0xFFFFFFFF (-1), E_RT=0x00000002 -> E_Busy high for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE when Busy falls.
- multu with E_RS=0xFFFFFFFF, E_RT=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div with E_RS=0xFFFFFFF9 (-7), E_RT=2 -> after exactly 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with 7/0 -> HI/LO retain their previous values.
- During busy, change E_RS/E_RT and pulse E_Start with mthi -> ignored; the result matches the originally latched operands. After completion, mthi 0x12345678 -> HI=0x12345678 on the next edge and E_Busy stays 0.
- Start div, then drive reset low asynchronously (between clock edges) in busy cycle 4 -> E_Busy, E_HI and E_LO read 0 immediately, and no later update occurs after release.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Back-to-back: Start held across the completion edge -> the second op starts one cycle after Busy falls.
